// File: rtl/hist_pkg.sv
// Shared histogram-stage types and sizing constants.
// Scratch depth is also consumed by the downstream CDF stage.
package hist_pkg;

  localparam int PIX_W_D    = 8;
  localparam int BIN_BITS_D = 6;
  localparam int CNT_W_D    = 16;
  localparam int NUM_BINS_D = 2 ** BIN_BITS_D;

  localparam int SCRATCH_DEPTH = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } hist_state_e;

endpackage

// File: rtl/hist_bin_ram.sv
// Bin count storage: 1R1W, synchronous read, old data on collision.
// Only the read register is reset; contents are cleared by the FSM.
module hist_bin_ram
  import hist_pkg::*;
#(
  parameter int BIN_BITS = BIN_BITS_D,
  parameter int CNT_W    = CNT_W_D
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BIN_BITS-1:0] i_rd_addr,
  output logic [CNT_W-1:0]    o_rd_data,
  input  logic                i_we,
  input  logic [BIN_BITS-1:0] i_wr_addr,
  input  logic [CNT_W-1:0]    i_wr_data
);

  localparam int NB = 2 ** BIN_BITS;

  logic [CNT_W-1:0] r_mem [NB];
  logic [CNT_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/hist_accum.sv
// Histogram build stage: clear, accumulate pixel bins, drain to scratch.
// Two-stage read-modify-write with forwarding for back-to-back bins.
module hist_accum
  import hist_pkg::*;
#(
  parameter int PIX_W    = PIX_W_D,
  parameter int BIN_BITS = BIN_BITS_D,
  parameter int CNT_W    = CNT_W_D
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                img_start,
  input  logic                pix_valid,
  input  logic [PIX_W-1:0]    pix_data,
  input  logic                pix_last,
  output logic                pix_ready,
  output logic                hist_wr_en,
  output logic [BIN_BITS-1:0] hist_wr_addr,
  output logic [CNT_W-1:0]    hist_wr_data,
  output logic                cdf_start,
  output logic                busy
);

  localparam int NB = 2 ** BIN_BITS;
  localparam logic [BIN_BITS:0] A_LAST = NB - 1;
  localparam logic [BIN_BITS:0] A_ONE  = 1;
  localparam logic [CNT_W-1:0]  C_ONE  = 1;

  hist_state_e r_state;

  logic [BIN_BITS:0]   r_addr;
  logic                r_pix_ready;
  logic                r_wr_en;
  logic [BIN_BITS-1:0] r_wr_addr;
  logic                r_cdf;
  logic                r_busy;
  logic                r_s1_vld;
  logic [BIN_BITS-1:0] r_s1_bin;
  logic                r_fwd;
  logic [CNT_W-1:0]    r_fwd_data;

  logic                w_xfer;
  logic [BIN_BITS-1:0] w_bin;
  logic [CNT_W-1:0]    w_rd_data;
  logic [CNT_W-1:0]    w_src;
  logic [CNT_W-1:0]    w_new;
  logic                w_we;
  logic [BIN_BITS-1:0] w_wa;
  logic [CNT_W-1:0]    w_wd;
  logic [BIN_BITS-1:0] w_ra;
  logic                w_unused;

  assign w_xfer   = pix_valid & r_pix_ready;
  assign w_bin    = pix_data[PIX_W-1 -: BIN_BITS];
  assign w_unused = ^pix_data[PIX_W-BIN_BITS-1:0];

  // RAM read is one cycle stale if S2 wrote this bin as S1 read it
  assign w_src = r_fwd ? r_fwd_data : w_rd_data;
  assign w_new = (&w_src) ? w_src : w_src + C_ONE;

  always_comb begin
    w_we = r_s1_vld;
    w_wa = r_s1_bin;
    w_wd = w_new;
    w_ra = w_bin;
    if (r_state == S_CLEAR) begin
      w_we = 1'b1;
      w_wa = r_addr[BIN_BITS-1:0];
      w_wd = '0;
    end
    if (r_state == S_DRAIN) begin
      w_ra = r_addr[BIN_BITS-1:0];
    end
  end

  hist_bin_ram #(
    .BIN_BITS (BIN_BITS),
    .CNT_W    (CNT_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .i_rd_addr (w_ra),
    .o_rd_data (w_rd_data),
    .i_we      (w_we),
    .i_wr_addr (w_wa),
    .i_wr_data (w_wd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_pix_ready <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_cdf       <= 1'b0;
      r_busy      <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_bin    <= '0;
      r_fwd       <= 1'b0;
      r_fwd_data  <= '0;
    end else begin
      r_s1_vld   <= w_xfer;
      r_s1_bin   <= w_bin;
      r_fwd      <= w_xfer & r_s1_vld & (w_bin == r_s1_bin);
      r_fwd_data <= w_new;
      r_wr_en    <= 1'b0;
      r_cdf      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (img_start) begin
            r_state <= S_CLEAR;
            r_addr  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_addr <= r_addr + A_ONE;
          if (r_addr == A_LAST) begin
            r_state     <= S_ACCUM;
            r_pix_ready <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_xfer && pix_last) begin
            r_state     <= S_FLUSH;
            r_pix_ready <= 1'b0;
            r_addr      <= '0;
          end
        end
        S_FLUSH: begin
          r_addr <= r_addr + A_ONE;
          if (r_addr[0]) begin
            r_state <= S_DRAIN;
            r_addr  <= '0;
          end
        end
        S_DRAIN: begin
          if (r_addr[BIN_BITS]) begin
            r_state <= S_DONE;
            r_cdf   <= 1'b1;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr[BIN_BITS-1:0];
            r_addr    <= r_addr + A_ONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pix_ready    = r_pix_ready;
  assign hist_wr_en   = r_wr_en;
  assign hist_wr_addr = r_wr_addr;
  assign hist_wr_data = w_rd_data;
  assign cdf_start    = r_cdf;
  assign busy         = r_busy;

endmodule

// File: tb/tb_hist_accum.sv
// Directed bench for hist_accum: 16-bit and 4-bit count instances
// driven in lockstep, drained histograms compared to hand values.
module tb_hist_accum;

  logic       clk = 1'b0;
  logic       reset;
  logic       img_start;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_last;

  logic        rdy, wen, cdf, bsy;
  logic [5:0]  wad;
  logic [15:0] wdat;
  logic        rdy4, wen4, cdf4, bsy4;
  logic [5:0]  wad4;
  logic [3:0]  wdat4;

  always #5 clk = ~clk;

  hist_accum u_dut (
    .clk          (clk),
    .reset        (reset),
    .img_start    (img_start),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_last     (pix_last),
    .pix_ready    (rdy),
    .hist_wr_en   (wen),
    .hist_wr_addr (wad),
    .hist_wr_data (wdat),
    .cdf_start    (cdf),
    .busy         (bsy)
  );

  hist_accum #(.CNT_W(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .img_start    (img_start),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_last     (pix_last),
    .pix_ready    (rdy4),
    .hist_wr_en   (wen4),
    .hist_wr_addr (wad4),
    .hist_wr_data (wdat4),
    .cdf_start    (cdf4),
    .busy         (bsy4)
  );

  int n_chk = 0;
  int n_err = 0;

  int got [64];
  int got4 [64];
  int exp_h [64];
  int n_wr, n_cdf, order_bad, cdf_bad;
  bit prev63;

  logic [7:0] px_q [$];
  int         gp_q [$];

  task automatic chk(input string tag, input int obs, input int req);
    n_chk++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, req);
    end
  endtask

  always @(negedge clk) begin
    if (wen) begin
      if (int'(wad) != n_wr) order_bad = 1;
      got[wad]  = int'(wdat);
      got4[wad] = int'(wdat4);
      n_wr++;
    end
    if (wen4 != wen || cdf4 != cdf) order_bad = 1;
    if (cdf) begin
      n_cdf++;
      if (!prev63) cdf_bad = 1;
    end
    prev63 = wen && (wad == 6'd63);
  end

  task automatic clr();
    for (int i = 0; i < 64; i++) begin
      exp_h[i] = 0;
      got[i]   = -1;
      got4[i]  = -1;
    end
    n_wr = 0; n_cdf = 0; order_bad = 0; cdf_bad = 0;
  endtask

  task automatic start_image(input bit stuff);
    int k;
    @(posedge clk); #1;
    img_start = 1'b1;
    for (k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      img_start = 1'b0;
      if (stuff) begin
        pix_valid = 1'b1; pix_data = 8'h00; pix_last = 1'b1;
      end
      if (rdy) break;
    end
    chk("ready_latency", k, 65);
  endtask

  task automatic send_pixels(input bit last, input int poke);
    for (int i = 0; i < px_q.size(); i++) begin
      for (int g = 0; g < gp_q[i]; g++) begin
        pix_valid = 1'b0; pix_data = 8'h00; pix_last = 1'b1;
        @(posedge clk); #1;
      end
      pix_valid = 1'b1;
      pix_data  = px_q[i];
      pix_last  = last && (i == px_q.size() - 1);
      img_start = (i == poke);
      @(posedge clk); #1;
      img_start = 1'b0;
    end
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  task automatic finish_image(input bit stuff);
    chk("ready_drop", int'(rdy), 0);
    for (int k = 0; k < 200; k++) begin
      if (n_cdf > 0) break;
      if (stuff) begin
        pix_valid = 1'b1; pix_data = 8'h00; pix_last = 1'b1;
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0; pix_last = 1'b0;
    chk("cdf_count", n_cdf, 1);
    chk("busy_idle", int'(bsy), 0);
    chk("wr_count", n_wr, 64);
    chk("wr_order", order_bad, 0);
    chk("cdf_after_63", cdf_bad, 0);
  endtask

  task automatic check_hist(input string tag, input bit sat16);
    int e4;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("%s_line%0d", tag, i), got[i], exp_h[i]);
      if (!sat16) begin
        e4 = exp_h[i] > 15 ? 15 : exp_h[i];
        chk($sformatf("%s_c4_line%0d", tag, i), got4[i], e4);
      end
    end
  endtask

  initial begin
    reset = 1'b1; img_start = 1'b0;
    pix_valid = 1'b0; pix_data = 8'h00; pix_last = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(rdy), 0);
    chk("rst_wr_en", int'(wen), 0);
    chk("rst_wr_data", int'(wdat), 0);
    chk("rst_cdf", int'(cdf), 0);
    chk("rst_busy", int'(bsy), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // single pixel 0x00
    clr();
    px_q = '{8'h00}; gp_q = '{0};
    start_image(1'b0);
    chk("busy_run", int'(bsy), 1);
    send_pixels(1'b1, -1);
    finish_image(1'b0);
    exp_h[0] = 1;
    check_hist("one", 1'b0);

    // back-to-back same bin
    clr();
    px_q = '{8'h43, 8'h43, 8'h43, 8'h43, 8'h43};
    gp_q = '{0, 0, 0, 0, 0};
    start_image(1'b0);
    send_pixels(1'b1, -1);
    finish_image(1'b0);
    exp_h[16] = 5;
    check_hist("b2b", 1'b0);

    // mixed stream
    clr();
    px_q = '{8'h43, 8'h44, 8'h43, 8'hFF, 8'h43};
    gp_q = '{0, 0, 0, 0, 0};
    start_image(1'b0);
    send_pixels(1'b1, -1);
    finish_image(1'b0);
    exp_h[16] = 3; exp_h[17] = 1; exp_h[63] = 1;
    check_hist("mix", 1'b0);

    // same stream with gaps, valid held during CLEAR and FLUSH
    clr();
    gp_q = '{0, 1, 0, 2, 1};
    start_image(1'b1);
    send_pixels(1'b1, -1);
    finish_image(1'b1);
    exp_h[16] = 3; exp_h[17] = 1; exp_h[63] = 1;
    check_hist("gap", 1'b0);

    // saturation: 20 x 0x10
    clr();
    px_q.delete(); gp_q.delete();
    for (int i = 0; i < 20; i++) begin
      px_q.push_back(8'h10); gp_q.push_back(0);
    end
    start_image(1'b0);
    send_pixels(1'b1, -1);
    finish_image(1'b0);
    exp_h[4] = 20;
    check_hist("sat", 1'b1);
    chk("sat_c4_line4", got4[4], 15);
    chk("sat_c4_line3", got4[3], 0);

    // reset mid-ACCUM, then new image with ignored img_start
    clr();
    px_q.delete(); gp_q.delete();
    for (int i = 0; i < 10; i++) begin
      px_q.push_back(8'h80); gp_q.push_back(0);
    end
    start_image(1'b0);
    send_pixels(1'b0, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", int'(rdy), 0);
    chk("mid_rst_busy", int'(bsy), 0);
    chk("mid_rst_wr_en", int'(wen), 0);
    reset = 1'b0;
    clr();
    repeat (4) @(posedge clk);
    #1;
    px_q = '{8'h80, 8'h80, 8'h80}; gp_q = '{0, 0, 0};
    start_image(1'b0);
    chk("pre_drain_wr", n_wr + n_cdf, 0);
    send_pixels(1'b1, 1);
    finish_image(1'b0);
    exp_h[32] = 3;
    check_hist("rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hist_accum.md
Name: hist_accum

Overview:
- Histogram-build stage directly upstream of the CDF controller.
- Consumes one image's pixel stream and bins each pixel into 64 bins.
- Writes the finished histogram, one line per bin, into scratch memory.
- Pulses cdf_start so the CDF stage can begin reading lines 0..63.

Parameters:
- PIX_W, 8, pixel width in bits.
- BIN_BITS, 6, bin index width; NUM_BINS = 2**BIN_BITS = 64.
- CNT_W, 16, bin count width; counts saturate at 2**CNT_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- img_start  in  1  single-cycle request to begin a new image; sampled only in IDLE.
- pix_valid  in  1  pixel present on pix_data.
- pix_data  in  PIX_W  pixel value.
- pix_last  in  1  marks the final pixel of the image; qualified by pix_valid.
- pix_ready  out  1  block accepts a pixel this cycle; transfer = pix_valid & pix_ready.
- hist_wr_en  out  1  scratch-memory write strobe.
- hist_wr_addr  out  BIN_BITS  scratch line (bin index).
- hist_wr_data  out  CNT_W  bin count.
- cdf_start  out  1  one-cycle pulse: histogram complete in scratch memory.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Outputs are registered. In reset: all outputs 0, state = IDLE, counters = 0. Bin RAM contents are not cleared by reset; CLEAR does that.
- Bin index = pix_data[PIX_W-1 -: BIN_BITS], i.e. the top 6 bits.
- Bin RAM: 1 read port + 1 write port, synchronous read with 1-cycle latency. Same-address read and write in the same cycle returns the OLD value.
- IDLE:
  - pix_ready = 0.
  - img_start = 1 -> CLEAR, addr counter = 0.
- CLEAR:
  - Writes 0 to bin[addr], addr++, for 64 cycles (addresses 0..63), then -> ACCUM.
  - pix_ready first goes high in the 65th cycle after img_start is sampled.
- ACCUM:
  - pix_ready = 1.
  - Two-stage pipeline.
  - S1 (transfer cycle): issue a RAM read of the bin; register the bin and a valid bit.
  - S2 (next cycle): new = src + 1, saturating at all-ones; write new to bin.
  - src = rd_data, unless the S1 read collided with the S2 write of the same bin in that cycle. In that case src = the registered value written then (forwarding). This is mandatory; back-to-back same-bin pixels must count exactly.
  - pix_valid gaps insert bubbles; no count changes for bubbles.
  - Transfer with pix_last = 1 -> FLUSH; pix_ready drops the following cycle.
- FLUSH:
  - pix_ready = 0.
  - Waits 2 cycles so S1/S2 retire, then -> DRAIN with addr = 0.
- DRAIN:
  - Reads bins 0..63 in order.
  - hist_wr_en is high for exactly 64 consecutive cycles, one cycle after each read (65 cycles in state).
  - hist_wr_addr = 0..63 ascending; hist_wr_data = bin count.
  - After the write of line 63 -> DONE.
- DONE:
  - cdf_start = 1 for exactly one cycle, in the cycle after the line-63 write; then -> IDLE.
- img_start outside IDLE is ignored.
- pix_valid outside ACCUM is ignored; no transfer because pix_ready = 0.
- pix_last on a non-transferring cycle has no effect.
- An image of one pixel (pix_last on the first transfer) is legal.
- Reset mid-operation, any state: -> IDLE next cycle.
  - pix_ready, hist_wr_en and cdf_start go to 0 immediately (registered).
  - Pipeline valid bits are cleared.
  - The next image is correct because CLEAR runs again.
- Saturation: a bin at 2**CNT_W-1 stays there; no wrap.
- Total pixel count is not tracked; image length is defined by pix_last alone.

Decomposition:
- Shared package hist_pkg holds:
  - state enum (IDLE, CLEAR, ACCUM, FLUSH, DRAIN, DONE);
  - NUM_BINS, BIN_BITS, CNT_W defaults;
  - the 64-line scratch depth constant, shared with the CDF stage.
- Sub-module hist_bin_ram: NUM_BINS x CNT_W, 1R1W, sync read, read-old-on-collision.
- Forwarding, saturation and the FSM live in hist_accum.

Test Plan:
- Single pixel 0x00 with pix_last after img_start:
  - DRAIN writes line 0 = 1 and lines 1..63 = 0.
  - cdf_start pulses once, one cycle after line 63.
  - busy returns to 0.
- Back-to-back stream 0x43 x5, last on the 5th, pix_valid continuous:
  - line 16 = 5 (checks forwarding); all other lines = 0.
- Stream 0x43,0x44,0x43,0xFF,0x43 (last):
  - line 16 = 3, line 17 = 1, line 63 = 1.
- Same stream as the previous case with pix_valid gaps of 1 and 2 cycles:
  - identical histogram.
  - No transfer while in CLEAR or FLUSH.
- CNT_W = 4, 20 pixels of 0x10:
  - line 4 = 15 (saturated), no wrap.
- Reset asserted mid-ACCUM after 10 pixels of 0x80, then a new image of 3 pixels 0x80:
  - line 32 = 3.
  - No hist_wr_en or cdf_start activity between the reset and the new DRAIN.
  - An img_start pulsed during ACCUM of the new image is ignored.
